// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: merges the PS/2 key stream and four joystick words into
// per-player control vectors, plus debounced start and coin signals.
// Optional macro INPUT_COIN_STRETCH_EN turns each coin press into exactly one
// COIN_CYCLES-long pulse. When the macro is undefined, coin follows the
// debounced level.
module arcade_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 40000,
  parameter int COIN_CYCLES     = 1600000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic [15:0] joy3,
  input  logic [15:0] joy4,
  output logic [5:0]  ctl1,
  output logic [5:0]  ctl2,
  output logic        start1,
  output logic        start2,
  output logic        coin,
  output logic        key_evt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  // Debounce channel indices.
  localparam int CH_START1 = 0;
  localparam int CH_START2 = 1;
  localparam int CH_COIN   = 2;

  logic       tog_q;
  logic       key_evt_q;
  logic [5:0] p1_q;      // {fireB, fireA, up, down, left, right}
  logic [5:0] p2_q;
  logic       k_start1_q;
  logic       k_start2_q;
  logic       k_coin1_q;
  logic       k_coin2_q;

  logic [5:0] ctl1_q;
  logic [5:0] ctl2_q;
  logic [2:0] raw_q;
  logic [2:0] db_q;
  logic [DW-1:0] cnt_q [3];

  logic       evt;
  logic       pressed;
  logic [7:0] code;
  logic [8:7] joy_any;

  assign evt     = ps2_key[10] != tog_q;
  assign pressed = ps2_key[9];
  assign code    = ps2_key[7:0];
  assign joy_any = joy1[8:7] | joy2[8:7] | joy3[8:7] | joy4[8:7];

  // Event detect and key latches: each PS/2 event writes the latch its code selects.
  always_ff @(posedge clk_sys) begin
    // NOTE: every register here uses <= so all flops sample pre-edge values together.
    if (reset) begin
      // Load the current toggle so no spurious event follows reset.
      tog_q      <= ps2_key[10];
      key_evt_q  <= 1'b0;
      p1_q       <= '0;
      p2_q       <= '0;
      k_start1_q <= 1'b0;
      k_start2_q <= 1'b0;
      k_coin1_q  <= 1'b0;
      k_coin2_q  <= 1'b0;
    end else begin
      tog_q     <= ps2_key[10];
      key_evt_q <= evt;
      if (evt) begin
        case (code)
          8'h74: p1_q[0] <= pressed;
          8'h6B: p1_q[1] <= pressed;
          8'h72: p1_q[2] <= pressed;
          8'h75: p1_q[3] <= pressed;
          8'h14: p1_q[4] <= pressed;
          8'h11: p1_q[5] <= pressed;
          8'h34: p2_q[0] <= pressed;
          8'h23: p2_q[1] <= pressed;
          8'h2B: p2_q[2] <= pressed;
          8'h2D: p2_q[3] <= pressed;
          8'h1C: p2_q[4] <= pressed;
          8'h1B: p2_q[5] <= pressed;
          8'h05, 8'h16: k_start1_q <= pressed;
          8'h06, 8'h1E: k_start2_q <= pressed;
          8'h76, 8'h2E: k_coin1_q  <= pressed;
          8'h36:        k_coin2_q  <= pressed;
          default: ;  // unmapped code: still reported on key_evt, no latch moves
        endcase
      end
    end
  end

  // Merge register: OR key latches with joystick bits; controls go out from here.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ctl1_q <= '0;
      ctl2_q <= '0;
      raw_q  <= '0;
    end else begin
      ctl1_q           <= p1_q | joy1[5:0];
      ctl2_q           <= p2_q | joy2[5:0];
      raw_q[CH_START1] <= k_start1_q | joy1[6];
      raw_q[CH_START2] <= k_start2_q | joy_any[7] | joy2[6];
      raw_q[CH_COIN]   <= k_coin1_q | k_coin2_q | joy_any[8];
    end
  end

  // Debounce: state follows raw only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      db_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (raw_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          // This cycle is the DEBOUNCE_CYCLES-th mismatch: accept the new level.
          db_q[i]  <= raw_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef INPUT_COIN_STRETCH_EN
  localparam int CW = $clog2(COIN_CYCLES + 1);

  logic          db_coin_prev_q;
  logic          pulse_q;
  logic [CW-1:0] pulse_cnt_q;

  // Coin stretch: a rising debounced edge fires one COIN_CYCLES pulse; edges during it are ignored.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      db_coin_prev_q <= 1'b0;
      pulse_q        <= 1'b0;
      pulse_cnt_q    <= '0;
    end else begin
      db_coin_prev_q <= db_q[CH_COIN];
      if (pulse_q) begin
        if (pulse_cnt_q == CW'(COIN_CYCLES - 1)) begin
          pulse_q <= 1'b0;
        end else begin
          pulse_cnt_q <= pulse_cnt_q + 1'b1;
        end
      end else if (db_q[CH_COIN] && !db_coin_prev_q) begin
        pulse_q     <= 1'b1;
        pulse_cnt_q <= '0;
      end
    end
  end

  assign coin = pulse_q;
`else
  assign coin = db_q[CH_COIN];
`endif

  assign ctl1    = ctl1_q;
  assign ctl2    = ctl2_q;
  assign start1  = db_q[CH_START1];
  assign start2  = db_q[CH_START2];
  assign key_evt = key_evt_q;

  // Inputs with no function in this core (extended flag, spare joystick bits).
  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joy1[15:9], joy2[15:9], joy3[15:9], joy4[15:9],
                         joy3[6:0], joy4[6:0], (COIN_CYCLES > 0)};

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed self-checking bench for arcade_input_ctrl with DEBOUNCE_CYCLES=4, COIN_CYCLES=10.
// Expected coin behaviour follows INPUT_COIN_STRETCH_EN when the bench is built with it.
module tb_arcade_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joy1, joy2, joy3, joy4;
  logic [5:0]  ctl1, ctl2;
  logic        start1, start2, coin, key_evt;

  int checks   = 0;
  int failures = 0;
  logic tog = 1'b0;

  arcade_input_ctrl #(.DEBOUNCE_CYCLES(4), .COIN_CYCLES(10)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_key (ps2_key),
    .joy1    (joy1),
    .joy2    (joy2),
    .joy3    (joy3),
    .joy4    (joy4),
    .ctl1    (ctl1),
    .ctl2    (ctl2),
    .start1  (start1),
    .start2  (start2),
    .coin    (coin),
    .key_evt (key_evt)
  );

  always #5 clk_sys = ~clk_sys;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one PS/2 event (toggle flips) and clock it in.
  task automatic send_key(input logic pressed, input logic [7:0] code);
    tog = ~tog;
    ps2_key = {tog, pressed, 1'b0, code};
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ctl1"},    32'(ctl1),    32'h0);
    check({tag, ".ctl2"},    32'(ctl2),    32'h0);
    check({tag, ".start1"},  32'(start1),  32'h0);
    check({tag, ".start2"},  32'(start2),  32'h0);
    check({tag, ".coin"},    32'(coin),    32'h0);
    check({tag, ".key_evt"}, 32'(key_evt), 32'h0);
  endtask

  initial begin
    logic exp_coin;
    logic seen;

    reset = 1'b1;
    ps2_key = '0;
    joy1 = '0; joy2 = '0; joy3 = '0; joy4 = '0;
    step(); step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Key press / release on P1 up (0x75 -> ctl1 bit 3).
    send_key(1'b1, 8'h75);
    check("press.key_evt", 32'(key_evt), 32'h1);
    check("press.ctl1_early", 32'(ctl1), 32'h0);
    step();
    check("press.ctl1", 32'(ctl1), 32'h08);
    check("press.key_evt_off", 32'(key_evt), 32'h0);
    send_key(1'b0, 8'h75);
    check("release.key_evt", 32'(key_evt), 32'h1);
    step();
    check("release.ctl1", 32'(ctl1), 32'h0);

    // Back-to-back events: P2 fireA then P2 right on consecutive cycles.
    send_key(1'b1, 8'h1C);
    check("b2b.evt1", 32'(key_evt), 32'h1);
    send_key(1'b1, 8'h34);
    check("b2b.evt2", 32'(key_evt), 32'h1);
    check("b2b.ctl2_first", 32'(ctl2), 32'h10);
    step();
    check("b2b.ctl2_both", 32'(ctl2), 32'h11);
    send_key(1'b0, 8'h1C);
    send_key(1'b0, 8'h34);
    step();
    check("b2b.ctl2_clear", 32'(ctl2), 32'h0);

    // Key and joystick OR together; releasing one leaves the output high.
    send_key(1'b1, 8'h6B);
    step();
    check("or.key_only", 32'(ctl1), 32'h02);
    joy1[1] = 1'b1;
    step();
    check("or.both", 32'(ctl1), 32'h02);
    send_key(1'b0, 8'h6B);
    step();
    check("or.joy_only", 32'(ctl1), 32'h02);
    joy1[1] = 1'b0;
    step();
    check("or.none", 32'(ctl1), 32'h0);

    // Joystick-only path: one register of latency.
    joy2[5:0] = 6'b101010;
    step();
    check("joy.ctl2", 32'(ctl2), 32'h2A);
    joy2[5:0] = '0;
    step();

    // joy4 select -> start2, debounced (rises 5 cycles after input).
    joy4[7] = 1'b1;
    repeat (4) step();
    check("start2.before", 32'(start2), 32'h0);
    step();
    check("start2.rise", 32'(start2), 32'h1);
    joy4[7] = 1'b0;
    repeat (4) step();
    check("start2.hold", 32'(start2), 32'h1);
    step();
    check("start2.fall", 32'(start2), 32'h0);

    // joy3 start is not a start source.
    joy3[6] = 1'b1;
    repeat (8) step();
    check("joy3start.start1", 32'(start1), 32'h0);
    check("joy3start.start2", 32'(start2), 32'h0);
    joy3[6] = 1'b0;

    // Glitch of 3 cycles on joy1 start never reaches start1.
    joy1[6] = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) joy1[6] = 1'b0;
      step();
      seen = seen | start1;
    end
    check("glitch.start1", 32'(seen), 32'h0);

    // Held 4 cycles: start1 rises exactly 5 cycles after the rise.
    joy1[6] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) joy1[6] = 1'b0;
      step();
      check($sformatf("held4.k%0d", k), 32'(start1), (k == 5) ? 32'h1 : 32'h0);
    end
    repeat (6) step();
    check("held4.released", 32'(start1), 32'h0);

    // Start1 from the keyboard (0x16): one extra cycle for the key latch.
    send_key(1'b1, 8'h16);
    repeat (4) step();
    check("kstart1.before", 32'(start1), 32'h0);
    step();
    check("kstart1.rise", 32'(start1), 32'h1);
    send_key(1'b0, 8'h16);
    repeat (5) step();
    check("kstart1.fall", 32'(start1), 32'h0);

    // Coin from joy3[8] held 50 cycles, observed over 60.
    joy3[8] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 51) joy3[8] = 1'b0;
      step();
`ifdef INPUT_COIN_STRETCH_EN
      exp_coin = (k >= 6 && k <= 15);
`else
      exp_coin = (k >= 5 && k <= 54);
`endif
      check($sformatf("coin.k%0d", k), 32'(coin), 32'(exp_coin));
    end

    // Reset mid-operation with a key latched and coin active.
    send_key(1'b1, 8'h75);
    step();
    check("midrst.ctl1_set", 32'(ctl1), 32'h08);
    joy3[8] = 1'b1;
    repeat (6) step();
    check("midrst.coin_set", 32'(coin), 32'h1);
    reset = 1'b1;
    joy3[8] = 1'b0;
    tog = ~tog;
    ps2_key = {tog, 1'b1, 1'b0, 8'h75};
    step();
    check_all_zero("midrst");
    reset = 1'b0;
    step();
    check("postrst.key_evt", 32'(key_evt), 32'h0);
    step();
    check_all_zero("postrst");

    // Unmapped code 0x29: pulse but no state change.
    send_key(1'b1, 8'h29);
    check("unmapped.key_evt", 32'(key_evt), 32'h1);
    repeat (6) step();
    check_all_zero("unmapped");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
